// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM with memory-ready wait/timeout and illegal-opcode flag.
// Optional macro MC_CTRL_JUMP_EN builds the JUMP state and decodes opcode 000010.
module mc_main_control #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] SLTIEX  = 4'd10;
    localparam logic [3:0] IWB     = 4'd11;
    localparam logic [3:0] JUMP    = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    logic [3:0]        state;
    logic [3:0]        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              timeout;
    logic              decode_illegal;

    assign waiting = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    // mem_ready takes priority over an expiring counter
    assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        next_state     = FETCH;
        decode_illegal = 1'b0;
        case (state)
            FETCH:   next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_SLTI:      next_state = SLTIEX;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:         next_state = JUMP;
`endif
                    default: begin
                        next_state     = FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)
                    next_state = MEMRD;
                else if (opcode == OP_SW)
                    next_state = MEMWR;
                else
                    next_state = FETCH;
            end
            MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
            MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
            EXECUTE: next_state = ALUWB;
            ADDIEX:  next_state = IWB;
            SLTIEX:  next_state = IWB;
            default: next_state = FETCH;
        endcase
        if (timeout)
            next_state = FETCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            // a timed-out FETCH keeps its state, so the timeout itself must clear the count
            if ((next_state != state) || mem_ready || timeout)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;
        state_dbg     = 4'd0;
        if (!rst) begin
            state_dbg   = state;
            illegal_op  = decode_illegal;
            mem_timeout = timeout;
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE:  alu_src_b = 2'b11;
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                SLTIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                end
                IWB:     reg_write = 1'b1;
`ifdef MC_CTRL_JUMP_EN
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the MIPS datapath.
- Decodes the 6-bit opcode held in the instruction register and sequences the fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable and mux select, including the 2-bit ALUOp that feeds the ALU control stage directly downstream.
- Adds a memory-ready handshake with a wait timeout, and flags illegal opcodes.

Parameters:
- WAIT_MAX, 15: maximum consecutive cycles to wait for mem_ready in a memory state before timeout.
- WAIT_W, 4: width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by the ALU zero flag (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-back data select: 1 = MDR.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = slt; goes to ALU control.
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- mem_timeout  out  1  one-cycle pulse on a wait timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Moore outputs decoded from the 4-bit state register; any output not listed for a state is 0.
- Reset:
  - While rst = 1, every output is forced to 0.
  - At the clock edge with rst = 1, the state becomes FETCH and the wait counter clears.
  - A reset mid-instruction abandons the instruction; no write enable asserts after the edge.
- Supported opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, slti = 001010, j = 000010 (see Optional Feature).
- States and encodings:
  - FETCH (0):
    - Outputs: mem_read = 1, alu_src_b = 01, alu_op = 00, pc_source = 00.
    - ir_write = pc_write = mem_ready.
    - Next: DECODE if mem_ready, else FETCH.
  - DECODE (1):
    - Outputs: alu_src_b = 11, alu_op = 00.
    - Next: lw/sw → MEMADR; R → EXECUTE; beq → BRANCH; addi → ADDIEX; slti → SLTIEX; j → JUMP.
    - Any other opcode: illegal_op = 1, next FETCH.
  - MEMADR (2):
    - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
    - Next: lw → MEMRD, sw → MEMWR.
  - MEMRD (3):
    - Outputs: mem_read = 1, i_or_d = 1.
    - Next: MEMWB if mem_ready, else MEMRD.
  - MEMWB (4):
    - Outputs: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
    - Next: FETCH.
  - MEMWR (5):
    - Outputs: mem_write = 1, i_or_d = 1.
    - Next: FETCH if mem_ready, else MEMWR.
  - EXECUTE (6):
    - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
    - Next: ALUWB.
  - ALUWB (7):
    - Outputs: reg_write = 1, reg_dst = 1.
    - Next: FETCH.
  - BRANCH (8):
    - Outputs: alu_src_a = 1, alu_op = 01, pc_write_cond = 1, pc_source = 01.
    - Next: FETCH.
  - ADDIEX (9):
    - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
    - Next: IWB.
  - SLTIEX (10):
    - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 11.
    - Next: IWB.
  - IWB (11):
    - Outputs: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
    - Next: FETCH.
  - JUMP (12):
    - Outputs: pc_write = 1, pc_source = 10.
    - Next: FETCH.
  - Encodings 13–15: all outputs 0, next FETCH.
- Instruction latency in cycles, assuming mem_ready is already high:
  - lw = 5; sw, R, addi, slti = 4; beq, j = 3.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - Clears on any state change and whenever mem_ready = 1.
- Timeout:
  - When the counter equals WAIT_MAX with mem_ready still 0, mem_timeout = 1 for that cycle.
  - The next state is FETCH and the counter clears.
  - A timed-out FETCH simply restarts the fetch.
- mem_ready arriving in the same cycle as the timeout: mem_ready wins; the state advances normally and there is no timeout pulse.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Optional Feature:
- Macro: MC_CTRL_JUMP_EN.
- Defined: opcode 000010 decodes to JUMP as listed above.
- Undefined:
  - The JUMP state is not built; encoding 12 behaves like 13–15.
  - Opcode 000010 is treated as illegal: illegal_op pulses in DECODE and the next state is FETCH.

Test Plan:
- rst held 3 cycles with mem_ready = 1 → all outputs 0 during reset; first cycle after release has state_dbg = 0, mem_read = 1, ir_write = 1, pc_write = 1, alu_src_b = 01.
- lw (100011), mem_ready = 1 → state sequence 0,1,2,3,4,0; alu_op = 00 in state 2; reg_write = 1 and mem_to_reg = 1 only in state 4.
- R-type (000000) then slti (001010) → alu_op = 10 in state 6, alu_op = 11 in state 10; reg_dst = 1 in state 7, reg_dst = 0 in state 11.
- sw with mem_ready low for 5 cycles in MEMWR → mem_write held 1 for 6 cycles, then state 0; mem_timeout stays 0.
- FETCH with mem_ready = 0 for 16 cycles, WAIT_MAX = 15 → mem_timeout pulses exactly once, on the 16th cycle; state stays 0.
- Opcode 111111 → illegal_op = 1 in DECODE, then FETCH; opcode 000010 → JUMP with pc_source = 10 when MC_CTRL_JUMP_EN is defined, illegal_op pulse when it is undefined.
